// File: rtl/btn_debouncer.sv
// Multi-channel push-button conditioner: 2-flop synchroniser, bounce filter,
// and registered level plus press/release pulses for each channel.
//
//   state     | meaning
//   ST_LOW    | output 0, waiting for synchronised input to go high
//   ST_ARM_HI | input high, counting towards acceptance of a press
//   ST_HIGH   | output 1, waiting for synchronised input to go low
//   ST_ARM_LO | input low, counting towards acceptance of a release
module btn_debouncer #(
    parameter int WIDTH         = 2,
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] BTN_IN,
    output logic [WIDTH-1:0] BTN_OUT,
    output logic [WIDTH-1:0] BTN_RISE,
    output logic [WIDTH-1:0] BTN_FALL
);

    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        ST_ARM_HI = 2'd1,
        ST_HIGH   = 2'd2,
        ST_ARM_LO = 2'd3
    } state_t;

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        state_t          state_q;
        logic [CW-1:0]   cnt_q;
        logic [CW-1:0]   cnt_d;
        logic            sync1_q;
        logic            sync2_q;
        logic            out_q;
        logic            rise_q;
        logic            fall_q;

        assign cnt_d = cnt_q + CNT_ONE;

        // The first differing sample counts as one, so acceptance lands on
        // the STABLE_CYCLES-th consecutive sample of the new level.
        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                state_q <= ST_LOW;
                cnt_q   <= '0;
                out_q   <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                sync1_q <= BTN_IN[g];
                sync2_q <= sync1_q;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                case (state_q)
                    ST_LOW: begin
                        cnt_q <= '0;
                        if (sync2_q) begin
                            state_q <= ST_ARM_HI;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                    ST_ARM_HI: begin
                        if (!sync2_q) begin
                            state_q <= ST_LOW;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= ST_HIGH;
                            cnt_q   <= '0;
                            out_q   <= 1'b1;
                            rise_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    ST_HIGH: begin
                        cnt_q <= '0;
                        if (!sync2_q) begin
                            state_q <= ST_ARM_LO;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                    ST_ARM_LO: begin
                        if (sync2_q) begin
                            state_q <= ST_HIGH;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= ST_LOW;
                            cnt_q   <= '0;
                            out_q   <= 1'b0;
                            fall_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    default: begin
                        state_q <= ST_LOW;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        assign BTN_OUT[g]  = out_q;
        assign BTN_RISE[g] = rise_q;
        assign BTN_FALL[g] = fall_q;
    end

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed and randomized bench for btn_debouncer with a run-length reference model.
module tb_btn_debouncer;
    localparam int W = 2;
    localparam int S = 4;

    logic         CLK   = 1'b0;
    logic         RST_N = 1'b0;
    logic [W-1:0] BTN_IN = '0;
    logic [W-1:0] BTN_OUT;
    logic [W-1:0] BTN_RISE;
    logic [W-1:0] BTN_FALL;

    always #5 CLK = ~CLK;

    btn_debouncer #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .BTN_IN   (BTN_IN),
        .BTN_OUT  (BTN_OUT),
        .BTN_RISE (BTN_RISE),
        .BTN_FALL (BTN_FALL)
    );

    int checks = 0;
    int errors = 0;

    // Reference: the filter sees BTN_IN two edges late; a channel flips once
    // S consecutive seen samples disagree with its current output.
    logic [W-1:0] m_h1, m_h2, m_out, m_rise, m_fall;
    int           m_run [W];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [W-1:0] btn, input logic rst);
        logic [W-1:0] seen;
        if (!rst) begin
            m_h1 = '0; m_h2 = '0; m_out = '0; m_rise = '0; m_fall = '0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            seen = m_h2;
            m_h2 = m_h1;
            m_h1 = btn;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < W; i++) begin
                if (seen[i] !== m_out[i]) m_run[i]++;
                else m_run[i] = 0;
                if (m_run[i] == S) begin
                    m_out[i] = ~m_out[i];
                    if (m_out[i]) m_rise[i] = 1'b1;
                    else m_fall[i] = 1'b1;
                    m_run[i] = 0;
                end
            end
        end
    endtask

    task automatic step(input logic [W-1:0] btn, input logic rst);
        BTN_IN = btn;
        RST_N  = rst;
        @(posedge CLK);
        model_edge(btn, rst);
        #1;
        chk("model_out",  BTN_OUT,  m_out);
        chk("model_rise", BTN_RISE, m_rise);
        chk("model_fall", BTN_FALL, m_fall);
        chk("pulse_excl", BTN_RISE & BTN_FALL, '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b1);
    endtask

    initial begin
        int           hold [W];
        logic [W-1:0] lvl;
        logic [W-1:0] ch1;
        int           ones;
        logic [6:0]   pat;

        // 1: reset with both buttons held, then requalify
        for (int e = 0; e < 3; e++) begin
            step(2'b11, 1'b0);
            chk("rst_out", BTN_OUT, 2'b00);
            chk("rst_rise", BTN_RISE, 2'b00);
            chk("rst_fall", BTN_FALL, 2'b00);
        end
        for (int e = 1; e <= 7; e++) begin
            step(2'b11, 1'b1);
            chk("t1_out", BTN_OUT, (e >= 6) ? 2'b11 : 2'b00);
            chk("t1_rise", BTN_RISE, (e == 6) ? 2'b11 : 2'b00);
        end
        for (int e = 1; e <= 7; e++) begin
            step(2'b00, 1'b1);
            chk("t1_fall", BTN_FALL, (e == 6) ? 2'b11 : 2'b00);
        end
        idle(4);

        // 2: clean press and release on channel 0
        for (int e = 1; e <= 7; e++) begin
            step(2'b01, 1'b1);
            chk("t2_out", BTN_OUT, (e >= 6) ? 2'b01 : 2'b00);
            chk("t2_rise", BTN_RISE, (e == 6) ? 2'b01 : 2'b00);
        end
        for (int e = 1; e <= 7; e++) begin
            step(2'b00, 1'b1);
            chk("t2_rel_out", BTN_OUT, (e >= 6) ? 2'b00 : 2'b01);
            chk("t2_fall", BTN_FALL, (e == 6) ? 2'b01 : 2'b00);
        end
        idle(4);

        // 3: bounce on channel 1
        pat = 7'b0101101;
        for (int e = 0; e < 15; e++) begin
            step((e < 7) ? {pat[e], 1'b0} : 2'b00, 1'b1);
            chk("t3_out", BTN_OUT, 2'b00);
            chk("t3_pulse", BTN_RISE | BTN_FALL, 2'b00);
        end

        // 4: threshold, 3 cycles rejected, 4 cycles accepted
        for (int e = 1; e <= 12; e++) begin
            step((e <= 3) ? 2'b01 : 2'b00, 1'b1);
            chk("t4_short", BTN_OUT | BTN_RISE | BTN_FALL, 2'b00);
        end
        for (int e = 1; e <= 14; e++) begin
            step((e <= 4) ? 2'b01 : 2'b00, 1'b1);
            chk("t4_out", BTN_OUT, (e >= 6 && e < 10) ? 2'b01 : 2'b00);
            chk("t4_rise", BTN_RISE, (e == 6) ? 2'b01 : 2'b00);
            chk("t4_fall", BTN_FALL, (e == 10) ? 2'b01 : 2'b00);
        end

        // 5: reset mid-count with button held
        for (int e = 1; e <= 3; e++) step(2'b01, 1'b1);
        step(2'b01, 1'b0);
        chk("t5_rst", BTN_OUT | BTN_RISE, 2'b00);
        for (int e = 1; e <= 8; e++) begin
            step(2'b01, 1'b1);
            chk("t5_rise", BTN_RISE, (e == 6) ? 2'b01 : 2'b00);
            chk("t5_out", BTN_OUT, (e >= 6) ? 2'b01 : 2'b00);
        end
        idle(8);

        // 6: channel 0 press while channel 1 bounces (runs of 1 kept below S)
        ones = 0;
        for (int e = 1; e <= 9; e++) begin
            ch1 = 2'($urandom_range(0, 1));
            if (ones >= S - 1) ch1 = '0;
            ones = ch1[0] ? ones + 1 : 0;
            step({ch1[0], 1'b1}, 1'b1);
            chk("t6_out", BTN_OUT, (e >= 6) ? 2'b01 : 2'b00);
            chk("t6_rise", BTN_RISE, (e == 6) ? 2'b01 : 2'b00);
            chk("t6_fall", BTN_FALL, 2'b00);
        end
        idle(10);

        // randomized hold lengths with rare resets, checked against the model
        for (int i = 0; i < W; i++) hold[i] = 0;
        lvl = '0;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < W; i++) begin
                if (hold[i] == 0) begin
                    lvl[i]  = 1'($urandom_range(0, 1));
                    hold[i] = $urandom_range(1, 8);
                end
                hold[i]--;
            end
            step(lvl, ($urandom_range(0, 99) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/btn_debouncer.md
# btn_debouncer

Multi-channel push-button conditioner between the board pins and the select/input logic of the top-level lab design. Each raw button is synchronised to the system clock and filtered against contact bounce. The block then presents a clean level plus single-cycle press and release pulses. Downstream logic (mux select, mode registers, counters) consumes only these conditioned signals, never raw BTN pins.

## Interface
- `WIDTH`, default 2: number of independent button channels.
- `STABLE_CYCLES`, default 1000000: cycles a synchronised input must hold a new level before it is accepted (10 ms at 100 MHz). Legal range is 2 or more.
- `CLK` input, 1 bit: system clock. All logic is on the rising edge.
- `RST_N` input, 1 bit: reset, synchronous, active-low.
- `BTN_IN` input, WIDTH bits: raw, asynchronous, bouncing button pins.
- `BTN_OUT` output, WIDTH bits: debounced level per channel.
- `BTN_RISE` output, WIDTH bits: one-cycle pulse when a channel's `BTN_OUT` goes 0 to 1 (press).
- `BTN_FALL` output, WIDTH bits: one-cycle pulse when a channel's `BTN_OUT` goes 1 to 0 (release).

## Operation
- **Channel independence:** channels are fully independent. Each channel has its own logic, with no shared counter and no cross-channel interaction.
- **Synchroniser:** per channel, two flops (`sync1`, `sync2`). `sync2` is the only signal the filter sees.
- **Counter:** per-channel counter, `$clog2(STABLE_CYCLES)` bits wide. It never exceeds `STABLE_CYCLES-1`, so there is no wrap-around.
- **Filter states:** each channel is in one of four states.
  - `LOW`: `BTN_OUT=0`, counter held at 0. Go to `ARM_HIGH` when `sync2=1`.
  - `ARM_HIGH`: counter increments each cycle while `sync2=1`.
    - If `sync2` returns to 0: counter cleared to 0, back to `LOW`, no pulse.
    - When the counter equals `STABLE_CYCLES-1` and `sync2=1`: go to `HIGH`, set `BTN_OUT=1`, pulse `BTN_RISE`, clear the counter.
  - `HIGH`: `BTN_OUT=1`, counter held at 0. Go to `ARM_LOW` when `sync2=0`.
  - `ARM_LOW`: mirror of `ARM_HIGH`.
    - If `sync2` returns to 1: back to `HIGH`, counter cleared to 0, no pulse.
    - On acceptance: go to `LOW`, set `BTN_OUT=0`, pulse `BTN_FALL`.
- **Bounce handling:** any glitch shorter than `STABLE_CYCLES` cycles (at `sync2`) produces no change on any output. Each reversal restarts the count from 0.
- **Reset:** while `RST_N=0` at a rising edge, the following are forced to 0 on that edge:
  - `sync1`, `sync2`
  - all counters, with every channel in state `LOW`
  - `BTN_OUT`, `BTN_RISE`, `BTN_FALL`
- **Reset mid-operation:** an in-progress count is discarded. A button still held after reset must requalify for the full `STABLE_CYCLES` period and then produces a `BTN_RISE`.
- **Pulse exclusivity:** `BTN_RISE` and `BTN_FALL` are never both 1 on the same channel. Each is high for exactly one cycle per accepted transition.

## Timing
- **Edge numbering:** edge 1 is the first rising edge that samples the new level of `BTN_IN`.
- **Synchroniser path:** `sync2` shows the new level after edge 2. The count runs over edges 3 through `STABLE_CYCLES+1`.
- **Output update:** `BTN_OUT` updates on edge `STABLE_CYCLES+2`, provided the input stays constant throughout. The matching pulse is asserted on the same edge and deasserted on the next edge.
- **Latency:** total input-to-output latency is `STABLE_CYCLES+2` cycles, identical for press and release.
- **Registered outputs:** all outputs are registered, with no combinational path from `BTN_IN`.
- **Minimum accepted hold:** a level at `sync2` must last at least `STABLE_CYCLES` consecutive cycles to be accepted. `STABLE_CYCLES-1` cycles is always rejected.
- **Simultaneous channels:** simultaneous transitions on several channels are handled in parallel with identical latency.

## Test plan
1. **Reset values:** hold `RST_N=0` for 3 cycles with `BTN_IN=2'b11`. Required: all outputs 0 throughout reset. After release, `BTN_OUT=2'b11` appears on edge 6, with `BTN_RISE=2'b11` for one cycle on that edge.
2. **Clean press and release (`STABLE_CYCLES=4`):** set `BTN_IN[0]` 0 to 1 and hold. Required: `BTN_OUT[0]=1` and `BTN_RISE[0]=1` on edge 6, `BTN_RISE[0]=0` on edge 7. Then release. Required: `BTN_FALL[0]` pulses on edge 6 after the release sample.
3. **Bounce rejection:** on `BTN_IN[1]`, apply the pattern 1,0,1,1,0,1,0 (one value per cycle) and then 0 steady. Required: `BTN_OUT[1]` stays 0 and no pulses occur.
4. **Threshold boundary (`STABLE_CYCLES=4`):**
   - Pulse `BTN_IN[0]` high for exactly 3 cycles. Required: no output change.
   - Pulse it high for exactly 4 cycles. Required: `BTN_OUT[0]` rises, then falls again after a further 6 edges.
5. **Reset mid-count:** press `BTN_IN[0]`, assert `RST_N=0` at edge 4 for 1 cycle, keep the button held. Required: no `BTN_RISE` before edge 6 counted from the first post-reset edge, then exactly one `BTN_RISE`.
6. **Independent channels:** press channel 0 while channel 1 bounces. Required: channel 0 follows scenario 2 timing exactly, and channel 1 outputs stay 0.
